// File: rtl/dma_dev_pkg.sv
// Shared types for the DMA device port: FSM encoding, completion status codes
// and parameter defaults.
package dma_dev_pkg;

  localparam int ADD_LEN_DEF     = 16;
  localparam int DATA_LEN_DEF    = 16;
  localparam int RXBUF_AW_DEF    = 2;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_XFER_RD = 3'd2,
    S_XFER_WR = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK       = 2'b00;
  localparam status_t ST_MISMATCH = 2'b01;
  localparam status_t ST_TIMEOUT  = 2'b10;

endpackage

// File: rtl/dma_dev_rxbuf.sv
// Receive-side FIFO for the DMA device port: 2^RXBUF_AW entries, first-word
// fall-through read port, free-entry count for early back-pressure.
module dma_dev_rxbuf #(
  parameter int DATA_LEN = 16,
  parameter int RXBUF_AW = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [DATA_LEN-1:0] push_data,
  input  logic                pop,
  output logic [DATA_LEN-1:0] pop_data,
  output logic                full,
  output logic                empty,
  output logic [RXBUF_AW:0]   free
);

  localparam int DEPTH = 1 << RXBUF_AW;
  localparam logic [RXBUF_AW:0] DEPTH_P = (RXBUF_AW+1)'(DEPTH);
  localparam logic [RXBUF_AW:0] ONE_P   = (RXBUF_AW+1)'(1);

  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [RXBUF_AW:0]   wr_ptr;
  logic [RXBUF_AW:0]   rd_ptr;
  logic [RXBUF_AW:0]   used;
  logic                do_push;
  logic                do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign used     = wr_ptr - rd_ptr;
  assign full     = (used == DEPTH_P);
  assign empty    = (used == '0);
  assign free     = DEPTH_P - used;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr[RXBUF_AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE_P;
      if (do_pop)  rd_ptr <= rd_ptr + ONE_P;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[RXBUF_AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dma_dev_port.sv
// Device-side port of the DMA controller: command handshake, request issue,
// word streaming in both directions. Optional idle watchdog: DMA_DEV_TIMEOUT_EN.
module dma_dev_port
  import dma_dev_pkg::*;
#(
  parameter int ADD_LEN     = ADD_LEN_DEF,
  parameter int DATA_LEN    = DATA_LEN_DEF,
  parameter int RXBUF_AW    = RXBUF_AW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rd_wr,
  input  logic [ADD_LEN-1:0]  cmd_num_words,
  input  logic [ADD_LEN:0]    cmd_addr,
  output logic                dma_rqst,
  output logic                dma_rd_wr,
  output logic [ADD_LEN-1:0]  dma_num_words,
  output logic [ADD_LEN:0]    dma_start_addr,
  output logic                dma_dev_ack,
  output logic [DATA_LEN-1:0] dma_wdata,
  input  logic [DATA_LEN-1:0] dma_rdata,
  input  logic                dma_ack_i,
  input  logic                dma_end,
  input  logic                tx_valid,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                tx_ready,
  output logic                rx_valid,
  output logic [DATA_LEN-1:0] rx_data,
  input  logic                rx_ready,
  output logic                done,
  output logic [1:0]          status
);

  localparam logic [RXBUF_AW:0] FREE_MIN = (RXBUF_AW+1)'(2);

  function automatic logic [ADD_LEN-1:0] sat_inc(input logic [ADD_LEN-1:0] v);
    return (&v) ? v : v + ADD_LEN'(1);
  endfunction

  state_t             state;
  logic [ADD_LEN-1:0] cnt;
  logic [ADD_LEN-1:0] cnt_nxt;
  logic               ovr;
  logic               ovr_now;
  logic               in_rd;
  logic               in_wr;
  logic               below;
  logic               rx_push;
  logic               word_acc;
  logic               rx_full;
  logic               rx_empty;
  logic [RXBUF_AW:0]  rx_free;

  assign in_rd    = (state == S_XFER_RD);
  assign in_wr    = (state == S_XFER_WR);
  assign below    = (cnt < dma_num_words);
  assign tx_ready = in_wr & dma_ack_i & dma_dev_ack;
  assign rx_push  = in_rd & dma_ack_i & below & ~rx_full;
  assign word_acc = rx_push | tx_ready;
  // An ack beyond the programmed count carries no data but taints the status.
  assign ovr_now  = (in_rd | in_wr) & dma_ack_i & ~below;
  assign cnt_nxt  = word_acc ? sat_inc(cnt) : cnt;
  assign dma_wdata = in_wr ? tx_data : '0;
  assign rx_valid = ~rx_empty;

  // Read side keeps one spare slot: the controller may land one more word
  // after dma_dev_ack drops.
  always_comb begin
    dma_dev_ack = 1'b0;
    case (state)
      S_XFER_RD: dma_dev_ack = (rx_free >= FREE_MIN);
      S_XFER_WR: dma_dev_ack = tx_valid & below;
      default:   dma_dev_ack = 1'b0;
    endcase
  end

`ifdef DMA_DEV_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     to_cnt <= '0;
    else if (!(in_rd | in_wr) || dma_ack_i || dma_end) to_cnt <= '0;
    else                                           to_cnt <= to_cnt + TO_W'(1);
  end

  assign to_hit = (in_rd | in_wr) & ~dma_ack_i & ~dma_end &
                  (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYC);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cmd_ready      <= 1'b1;
      dma_rqst       <= 1'b0;
      done           <= 1'b0;
      status         <= ST_OK;
      dma_rd_wr      <= 1'b0;
      dma_num_words  <= '0;
      dma_start_addr <= '0;
      cnt            <= '0;
      ovr            <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          dma_rd_wr      <= cmd_rd_wr;
          dma_num_words  <= cmd_num_words;
          dma_start_addr <= cmd_addr;
          cnt            <= '0;
          ovr            <= 1'b0;
          cmd_ready      <= 1'b0;
          dma_rqst       <= 1'b1;
          state          <= S_REQ;
        end
        S_REQ: begin
          dma_rqst <= 1'b0;
          state    <= dma_rd_wr ? S_XFER_RD : S_XFER_WR;
        end
        S_XFER_RD, S_XFER_WR: begin
          cnt <= cnt_nxt;
          ovr <= ovr | ovr_now;
          if (dma_end) begin
            done   <= 1'b1;
            status <= ((cnt_nxt != dma_num_words) || ovr || ovr_now) ? ST_MISMATCH : ST_OK;
            state  <= S_DONE;
          end
`ifdef DMA_DEV_TIMEOUT_EN
          else if (to_hit) begin
            done   <= 1'b1;
            status <= ST_TIMEOUT;
            state  <= S_ERR;
          end
`endif
        end
        S_DONE, S_ERR: begin
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  dma_dev_rxbuf #(
    .DATA_LEN (DATA_LEN),
    .RXBUF_AW (RXBUF_AW)
  ) u_rxbuf (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (dma_rdata),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .free      (rx_free)
  );

endmodule

// File: tb/tb_dma_dev_port.sv
// Directed self-checking bench for dma_dev_port; the controller side is driven
// by hand. Timeout scenario depends on DMA_DEV_TIMEOUT_EN.
module tb_dma_dev_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_rd_wr;
  logic [15:0] cmd_num_words;
  logic [16:0] cmd_addr;
  logic        dma_rqst, dma_rd_wr;
  logic [15:0] dma_num_words;
  logic [16:0] dma_start_addr;
  logic        dma_dev_ack;
  logic [15:0] dma_wdata, dma_rdata;
  logic        dma_ack_i, dma_end;
  logic        tx_valid, tx_ready;
  logic [15:0] tx_data;
  logic        rx_valid, rx_ready;
  logic [15:0] rx_data;
  logic        done;
  logic [1:0]  status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_dev_port #(
    .ADD_LEN(16), .DATA_LEN(16), .RXBUF_AW(2), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
    .cmd_num_words(cmd_num_words), .cmd_addr(cmd_addr),
    .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr), .dma_num_words(dma_num_words),
    .dma_start_addr(dma_start_addr), .dma_dev_ack(dma_dev_ack),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack_i(dma_ack_i),
    .dma_end(dma_end), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .done(done), .status(status)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  // Present one command for a cycle; returns on the negedge while in REQ.
  task automatic send_cmd(input logic rw, input logic [15:0] nw, input logic [16:0] addr);
    cmd_valid = 1'b1; cmd_rd_wr = rw; cmd_num_words = nw; cmd_addr = addr;
    tick;
    cmd_valid = 1'b0; cmd_rd_wr = 1'b0; cmd_num_words = '0; cmd_addr = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cmd_valid = 0; cmd_rd_wr = 0; cmd_num_words = 0; cmd_addr = 0;
    dma_rdata = 16'hDEAD; dma_ack_i = 1'b1; dma_end = 0;
    tx_valid = 1'b1; tx_data = 16'h0055; rx_ready = 0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (dma_rqst !== 1'b0) begin errors++; $display("FAIL rst_dma_rqst got %b exp 0", dma_rqst); end
    checks++; if (dma_dev_ack !== 1'b0) begin errors++; $display("FAIL rst_dev_ack got %b exp 0", dma_dev_ack); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_tx_ready got %b exp 0", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", rx_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL rst_status got %b exp 00", status); end
    checks++; if (dma_wdata !== 16'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0000", dma_wdata); end
    checks++; if (dma_num_words !== 16'h0 || dma_start_addr !== 17'h0 || dma_rd_wr !== 1'b0) begin errors++; $display("FAIL rst_dma_regs got nw=%h addr=%h rw=%b exp 0", dma_num_words, dma_start_addr, dma_rd_wr); end
    tick; tick;
    reset = 1'b0; dma_ack_i = 0; tx_valid = 0; tx_data = 0; dma_rdata = 0;
    tick;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_read4;
    logic [15:0] w;
    rx_ready = 1'b1;
    send_cmd(1'b1, 16'd4, 17'h00100);
    checks++; if (dma_rqst !== 1'b1) begin errors++; $display("FAIL rd4_rqst got %b exp 1", dma_rqst); end
    checks++; if (dma_rd_wr !== 1'b1) begin errors++; $display("FAIL rd4_rd_wr got %b exp 1", dma_rd_wr); end
    checks++; if (dma_num_words !== 16'd4) begin errors++; $display("FAIL rd4_num_words got %h exp 0004", dma_num_words); end
    checks++; if (dma_start_addr !== 17'h00100) begin errors++; $display("FAIL rd4_addr got %h exp 00100", dma_start_addr); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rd4_cmd_ready got %b exp 0", cmd_ready); end
    tick;
    checks++; if (dma_rqst !== 1'b0) begin errors++; $display("FAIL rd4_rqst_one_cycle got %b exp 0", dma_rqst); end
    checks++; if (dma_dev_ack !== 1'b1) begin errors++; $display("FAIL rd4_dev_ack got %b exp 1", dma_dev_ack); end
    for (int i = 0; i < 4; i++) begin
      w = 16'h1111 * 16'(i + 1);
      dma_ack_i = 1'b1; dma_rdata = w;
      tick;
      checks++; if (rx_valid !== 1'b1 || rx_data !== w) begin errors++; $display("FAIL rd4_rx_word%0d got v=%b d=%h exp v=1 d=%h", i, rx_valid, rx_data, w); end
    end
    checks++; if (dma_start_addr !== 17'h00100) begin errors++; $display("FAIL rd4_addr_stable got %h exp 00100", dma_start_addr); end
    dma_ack_i = 1'b0; dma_rdata = 0; dma_end = 1'b1;
    tick;
    checks++; if (done !== 1'b1 || status !== 2'b00) begin errors++; $display("FAIL rd4_done got done=%b st=%b exp done=1 st=00", done, status); end
    dma_end = 1'b0;
    tick;
    checks++; if (done !== 1'b0 || cmd_ready !== 1'b1 || rx_valid !== 1'b0) begin errors++; $display("FAIL rd4_idle got done=%b rdy=%b rxv=%b exp 0 1 0", done, cmd_ready, rx_valid); end
  endtask

  task automatic test_read_backpressure;
    logic exp_ack [4];
    exp_ack[0] = 1; exp_ack[1] = 1; exp_ack[2] = 0; exp_ack[3] = 0;
    rx_ready = 1'b0;
    send_cmd(1'b1, 16'd4, 17'h00200);
    tick;
    for (int i = 0; i < 4; i++) begin
      dma_ack_i = 1'b1; dma_rdata = 16'hB000 + 16'(i);
      tick;
      checks++; if (dma_dev_ack !== exp_ack[i]) begin errors++; $display("FAIL bp_dev_ack%0d got %b exp %b", i, dma_dev_ack, exp_ack[i]); end
    end
    dma_ack_i = 1'b0; dma_end = 1'b1;
    tick;
    checks++; if (done !== 1'b1 || status !== 2'b00) begin errors++; $display("FAIL bp_done got done=%b st=%b exp 1 00", done, status); end
    dma_end = 1'b0;
    tick;
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_valid !== 1'b1 || rx_data !== 16'hB000 + 16'(i)) begin errors++; $display("FAIL bp_drain%0d got v=%b d=%h exp v=1 d=%h", i, rx_valid, rx_data, 16'hB000 + 16'(i)); end
      tick;
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got rx_valid=%b exp 0", rx_valid); end
  endtask

  task automatic test_write3;
    int k;
    int pulses;
    logic exp_ack;
    k = 0; pulses = 0;
    send_cmd(1'b0, 16'd3, 17'h00300);
    tick;
    for (int c = 0; c < 8; c++) begin
      tx_valid = ((c % 2) == 0);
      tx_data  = 16'h00A0 + 16'(k);
      #1; dma_ack_i = dma_dev_ack; #1;
      exp_ack = tx_valid && (k < 3);
      checks++; if (dma_dev_ack !== exp_ack || tx_ready !== exp_ack) begin errors++; $display("FAIL wr_ack_c%0d got ack=%b rdy=%b exp %b", c, dma_dev_ack, tx_ready, exp_ack); end
      if (tx_ready === 1'b1) pulses++;
      if (exp_ack) begin
        checks++; if (dma_wdata !== 16'h00A0 + 16'(k)) begin errors++; $display("FAIL wr_wdata%0d got %h exp %h", k, dma_wdata, 16'h00A0 + 16'(k)); end
        k++;
      end
      tick;
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL wr_pulses got %0d exp 3", pulses); end
    tx_valid = 1'b0; dma_ack_i = 1'b0; dma_end = 1'b1;
    tick;
    checks++; if (done !== 1'b1 || status !== 2'b00) begin errors++; $display("FAIL wr_done got done=%b st=%b exp 1 00", done, status); end
    dma_end = 1'b0;
    tick;
  endtask

  task automatic test_mismatch_and_zero;
    rx_ready = 1'b1;
    send_cmd(1'b1, 16'd5, 17'h00400);
    tick;
    for (int i = 0; i < 3; i++) begin
      dma_ack_i = 1'b1; dma_rdata = 16'h5000 + 16'(i);
      tick;
    end
    dma_ack_i = 1'b0; dma_end = 1'b1;
    tick;
    checks++; if (done !== 1'b1 || status !== 2'b01) begin errors++; $display("FAIL mm_short got done=%b st=%b exp 1 01", done, status); end
    dma_end = 1'b0;
    tick;
    send_cmd(1'b0, 16'd0, 17'h00010);
    checks++; if (dma_rqst !== 1'b1 || dma_num_words !== 16'd0 || dma_start_addr !== 17'h00010) begin errors++; $display("FAIL zero_req got rq=%b nw=%h a=%h exp 1 0000 00010", dma_rqst, dma_num_words, dma_start_addr); end
    tick;
    tx_valid = 1'b1; tx_data = 16'h00EE;
    #1;
    checks++; if (dma_dev_ack !== 1'b0) begin errors++; $display("FAIL zero_dev_ack got %b exp 0", dma_dev_ack); end
    tx_valid = 1'b0; dma_end = 1'b1;
    tick;
    checks++; if (done !== 1'b1 || status !== 2'b00) begin errors++; $display("FAIL zero_done got done=%b st=%b exp 1 00", done, status); end
    dma_end = 1'b0;
    tick;
  endtask

  task automatic test_overrun;
    send_cmd(1'b1, 16'd1, 17'h00020);
    tick;
    dma_ack_i = 1'b1; dma_rdata = 16'h00C0;
    tick;
    dma_rdata = 16'h00C1;
    tick;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_extra_stored got rx_valid=%b d=%h exp 0", rx_valid, rx_data); end
    dma_ack_i = 1'b0; dma_end = 1'b1;
    tick;
    checks++; if (done !== 1'b1 || status !== 2'b01) begin errors++; $display("FAIL ovr_status got done=%b st=%b exp 1 01", done, status); end
    dma_end = 1'b0;
    tick;
  endtask

  task automatic test_timeout;
    logic seen_done;
    seen_done = 1'b0;
    send_cmd(1'b1, 16'd2, 17'h00030);
    tick;
`ifdef DMA_DEV_TIMEOUT_EN
    for (int n = 1; n < 8; n++) begin
      tick;
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL to_early got done before cycle 8 exp none"); end
    tick;
    checks++; if (done !== 1'b1 || status !== 2'b10 || dma_dev_ack !== 1'b0) begin errors++; $display("FAIL to_err got done=%b st=%b ack=%b exp 1 10 0", done, status, dma_dev_ack); end
    tick;
    checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL to_idle got done=%b rdy=%b exp 0 1", done, cmd_ready); end
`else
    for (int n = 0; n < 20; n++) begin
      tick;
      if (done === 1'b1 || cmd_ready === 1'b1) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL nto_left_xfer got done/cmd_ready exp stay in XFER"); end
    dma_end = 1'b1;
    tick;
    checks++; if (done !== 1'b1 || status !== 2'b01) begin errors++; $display("FAIL nto_end got done=%b st=%b exp 1 01", done, status); end
    dma_end = 1'b0;
    tick;
`endif
  endtask

  task automatic test_reset_mid;
    logic seen_done;
    seen_done = 1'b0;
    send_cmd(1'b0, 16'd3, 17'h00040);
    tick;
    tx_valid = 1'b1; tx_data = 16'h0077; dma_ack_i = 1'b1;
    #1;
    checks++; if (dma_dev_ack !== 1'b1 || dma_wdata !== 16'h0077) begin errors++; $display("FAIL rm_pre got ack=%b wd=%h exp 1 0077", dma_dev_ack, dma_wdata); end
    #1; reset = 1'b1; #1;
    checks++; if (cmd_ready !== 1'b1 || dma_rqst !== 1'b0 || dma_dev_ack !== 1'b0 || tx_ready !== 1'b0) begin errors++; $display("FAIL rm_ctrl got rdy=%b rq=%b ack=%b txr=%b exp 1 0 0 0", cmd_ready, dma_rqst, dma_dev_ack, tx_ready); end
    checks++; if (rx_valid !== 1'b0 || done !== 1'b0 || status !== 2'b00) begin errors++; $display("FAIL rm_stat got rxv=%b done=%b st=%b exp 0 0 00", rx_valid, done, status); end
    checks++; if (dma_num_words !== 16'h0 || dma_start_addr !== 17'h0 || dma_wdata !== 16'h0) begin errors++; $display("FAIL rm_regs got nw=%h a=%h wd=%h exp 0", dma_num_words, dma_start_addr, dma_wdata); end
    for (int n = 0; n < 2; n++) begin
      tick;
      if (done === 1'b1) seen_done = 1'b1;
    end
    reset = 1'b0; tx_valid = 1'b0; dma_ack_i = 1'b0; tx_data = 0;
    tick;
    if (done === 1'b1) seen_done = 1'b1;
    checks++; if (seen_done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_after got done_seen=%b rdy=%b exp 0 1", seen_done, cmd_ready); end
  endtask

  initial begin
    test_reset;
    test_read4;
    test_read_backpressure;
    test_write3;
    test_mismatch_and_zero;
    test_overrun;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
